// File: rtl/aha_clk_gate_sequencer.sv
// Per-channel clock-gate sequencer: filters PMU gate requests, runs a Q-channel
// quiescence handshake with each peripheral and drives the ICG enables.
module aha_clk_gate_ch #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic qacceptn_i,
  input  logic qdeny_i,
  input  logic deny_clr_i,
  output logic qreqn_o,
  output logic gate_en_o,
  output logic deny_seen_o
);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    REQ   = 3'd1,
    GATED = 3'd2,
    EXIT  = 3'd3,
    WAKE  = 3'd4,
    DENY  = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             qreqn_q, gate_en_q, deny_seen_q;
  logic             deny_set;

  // A deny arriving on the same edge as a clear must stay visible.
  assign deny_set = (state_q == REQ) && qacceptn_i && qdeny_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      qreqn_q     <= 1'b1;
      gate_en_q   <= 1'b0;
      deny_seen_q <= 1'b0;
    end else begin
      deny_seen_q <= deny_set | (deny_seen_q & ~deny_clr_i);
      case (state_q)
        RUN: begin
          if (!req_i)
            cnt_q <= '0;
          else if (cnt_q != HOLD)
            cnt_q <= cnt_q + CNT_W'(1);
          else begin
            state_q <= REQ;
            qreqn_q <= 1'b0;
          end
        end
        REQ: begin
          // Accept wins over a simultaneous deny; req_i is ignored here.
          if (!qacceptn_i) begin
            state_q   <= GATED;
            gate_en_q <= 1'b1;
          end else if (qdeny_i) begin
            state_q <= DENY;
            qreqn_q <= 1'b1;
          end
        end
        GATED: begin
          if (!req_i) begin
            state_q   <= EXIT;
            gate_en_q <= 1'b0;
          end
        end
        EXIT: begin
          // Clock already running for one edge before QREQn is released.
          state_q <= WAKE;
          qreqn_q <= 1'b1;
        end
        WAKE: begin
          if (qacceptn_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
        DENY: begin
          if (!qdeny_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q   <= RUN;
          cnt_q     <= '0;
          qreqn_q   <= 1'b1;
          gate_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign qreqn_o     = qreqn_q;
  assign gate_en_o   = gate_en_q;
  assign deny_seen_o = deny_seen_q;
endmodule

module aha_clk_gate_sequencer #(
  parameter int NUM_CH      = 13,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CG_DISABLE,
  input  logic [NUM_CH-1:0] GATE_REQ,
  input  logic [NUM_CH-1:0] QACCEPTn,
  input  logic [NUM_CH-1:0] QDENY,
  output logic [NUM_CH-1:0] QREQn,
  output logic [NUM_CH-1:0] GATE_EN,
  output logic [NUM_CH-1:0] DENY_SEEN,
  input  logic [NUM_CH-1:0] DENY_CLR
);
  logic [NUM_CH-1:0] req;

  assign req = GATE_REQ & {NUM_CH{~CG_DISABLE}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aha_clk_gate_ch #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk         (CLK),
      .rst         (RESET),
      .req_i       (req[i]),
      .qacceptn_i  (QACCEPTn[i]),
      .qdeny_i     (QDENY[i]),
      .deny_clr_i  (DENY_CLR[i]),
      .qreqn_o     (QREQn[i]),
      .gate_en_o   (GATE_EN[i]),
      .deny_seen_o (DENY_SEEN[i])
    );
  end
endmodule

// File: tb/tb_aha_clk_gate_sequencer.sv
// Directed bench for aha_clk_gate_sequencer: handshake timing, glitch filter,
// deny/retry, withdrawal, global disable, async reset and a zero-hold build.
module tb_aha_clk_gate_sequencer;
  localparam int NCH = 13;
  localparam logic [12:0] ALL = 13'h1FFF;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            CG_DISABLE;
  logic [NCH-1:0]  GATE_REQ, QACCEPTn, QDENY, DENY_CLR;
  logic [NCH-1:0]  QREQn, GATE_EN, DENY_SEEN;

  logic            z_req, z_acc, z_deny, z_clr;
  logic            z_qreqn, z_gate, z_seen;

  logic [NCH-1:0]  ge_prev;
  int              n_chk = 0;
  int              n_fail = 0;

  always #5 CLK = ~CLK;

  aha_clk_gate_sequencer #(.NUM_CH(NCH), .HOLD_CYCLES(4), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .CG_DISABLE(CG_DISABLE), .GATE_REQ(GATE_REQ),
    .QACCEPTn(QACCEPTn), .QDENY(QDENY), .QREQn(QREQn), .GATE_EN(GATE_EN),
    .DENY_SEEN(DENY_SEEN), .DENY_CLR(DENY_CLR)
  );

  aha_clk_gate_sequencer #(.NUM_CH(1), .HOLD_CYCLES(0), .CNT_W(4)) dut0 (
    .CLK(CLK), .RESET(RESET), .CG_DISABLE(1'b0), .GATE_REQ(z_req),
    .QACCEPTn(z_acc), .QDENY(z_deny), .QREQn(z_qreqn), .GATE_EN(z_gate),
    .DENY_SEEN(z_seen), .DENY_CLR(z_clr)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later with the inputs that edge saw.
  task automatic tick();
    @(posedge CLK);
    #1;
    chk("inv_gate_qreqn", 16'(GATE_EN & QREQn), 16'h0);
    chk("inv_gate_accept", 16'(GATE_EN & ~ge_prev & QACCEPTn), 16'h0);
    ge_prev = GATE_EN;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    ticks(2);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; CG_DISABLE = 1'b0;
    GATE_REQ = '0; QACCEPTn = ALL; QDENY = '0; DENY_CLR = '0;
    z_req = 1'b0; z_acc = 1'b1; z_deny = 1'b0; z_clr = 1'b0;
    ge_prev = '0;
    ticks(2);
    chk("rst_qreqn", 16'(QREQn), 16'(ALL));
    chk("rst_gate", 16'(GATE_EN), 16'h0);
    chk("rst_deny_seen", 16'(DENY_SEEN), 16'h0);
    chk("rst_z_qreqn", 16'(z_qreqn), 16'h1);
    RESET = 1'b0;

    // Basic gate/ungate on channel 2
    GATE_REQ = 13'h0004;
    ticks(4);
    chk("basic_qreqn_e4", 16'(QREQn), 16'(ALL));
    tick();
    chk("basic_qreqn_e5", 16'(QREQn), 16'(ALL & ~13'h0004));
    tick();
    chk("basic_gate_e6", 16'(GATE_EN), 16'h0);
    QACCEPTn = ALL & ~13'h0004;
    tick();
    chk("basic_gate_e7", 16'(GATE_EN), 16'h0004);
    ticks(3);
    chk("basic_gate_hold", 16'(GATE_EN), 16'h0004);
    GATE_REQ = '0;
    tick();
    chk("basic_exit_gate", 16'(GATE_EN), 16'h0);
    chk("basic_exit_qreqn", 16'(QREQn), 16'(ALL & ~13'h0004));
    tick();
    chk("basic_wake_qreqn", 16'(QREQn), 16'(ALL));
    GATE_REQ = 13'h0004;
    ticks(6);
    chk("basic_wake_ignores_req", 16'(QREQn), 16'(ALL));
    QACCEPTn = ALL;
    tick();
    ticks(4);
    chk("basic_rerun_e4", 16'(QREQn), 16'(ALL));
    tick();
    chk("basic_rerun_e5", 16'(QREQn), 16'(ALL & ~13'h0004));
    GATE_REQ = '0;
    do_reset();

    // Glitch filter on channel 0
    GATE_REQ = 13'h0001;
    ticks(4);
    GATE_REQ = 13'h0000;
    tick();
    chk("glitch_low", 16'(QREQn), 16'(ALL));
    GATE_REQ = 13'h0001;
    ticks(4);
    chk("glitch_e4", 16'(QREQn), 16'(ALL));
    tick();
    chk("glitch_e5", 16'(QREQn), 16'(ALL & ~13'h0001));
    GATE_REQ = '0;
    do_reset();

    // Deny on channel 5, retry, clear, set-wins
    GATE_REQ = 13'h0020;
    ticks(5);
    chk("deny_qreqn_low", 16'(QREQn), 16'(ALL & ~13'h0020));
    QDENY = 13'h0020;
    tick();
    chk("deny_qreqn_high", 16'(QREQn), 16'(ALL));
    chk("deny_seen_set", 16'(DENY_SEEN), 16'h0020);
    ticks(2);
    chk("deny_gate_never", 16'(GATE_EN), 16'h0);
    chk("deny_hold_qreqn", 16'(QREQn), 16'(ALL));
    QDENY = '0;
    tick();
    ticks(4);
    chk("deny_retry_e4", 16'(QREQn), 16'(ALL));
    tick();
    chk("deny_retry_e5", 16'(QREQn), 16'(ALL & ~13'h0020));
    DENY_CLR = 13'h0020;
    tick();
    DENY_CLR = '0;
    chk("deny_clr", 16'(DENY_SEEN), 16'h0);
    QDENY = 13'h0020; DENY_CLR = 13'h0020;
    tick();
    QDENY = '0; DENY_CLR = '0;
    chk("deny_set_wins", 16'(DENY_SEEN), 16'h0020);
    GATE_REQ = '0;
    tick();
    chk("deny_back_run", 16'(QREQn), 16'(ALL));
    do_reset();

    // Withdrawal while in REQ on channel 1
    GATE_REQ = 13'h0002;
    ticks(5);
    GATE_REQ = '0;
    ticks(2);
    chk("wd_qreqn_held", 16'(QREQn), 16'(ALL & ~13'h0002));
    QACCEPTn = ALL & ~13'h0002;
    tick();
    chk("wd_gated_1cyc", 16'(GATE_EN), 16'h0002);
    tick();
    chk("wd_exit_gate", 16'(GATE_EN), 16'h0);
    chk("wd_exit_qreqn", 16'(QREQn), 16'(ALL & ~13'h0002));
    tick();
    chk("wd_wake_qreqn", 16'(QREQn), 16'(ALL));
    QACCEPTn = ALL;
    tick();

    // Global disable blocks every channel
    CG_DISABLE = 1'b1; GATE_REQ = ALL;
    ticks(10);
    chk("cgdis_qreqn", 16'(QREQn), 16'(ALL));
    CG_DISABLE = 1'b0;
    ticks(5);
    chk("all_qreqn_low", 16'(QREQn), 16'h0);
    QACCEPTn = '0;
    tick();
    chk("all_gated", 16'(GATE_EN), 16'(ALL));

    // Asynchronous reset mid-cycle, no clock edge in between
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst_gate", 16'(GATE_EN), 16'h0);
    chk("async_rst_qreqn", 16'(QREQn), 16'(ALL));
    GATE_REQ = '0; QACCEPTn = ALL;
    ticks(2);
    RESET = 1'b0;

    // Zero-hold build: QREQn falls on the first edge
    z_req = 1'b1;
    tick();
    chk("hold0_e1", 16'(z_qreqn), 16'h0);
    z_acc = 1'b0;
    tick();
    chk("hold0_gated", 16'(z_gate), 16'h1);
    z_req = 1'b0;
    tick();
    chk("hold0_exit", 16'(z_gate), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aha_clk_gate_sequencer.md
Name: aha_clk_gate_sequencer

Overview:
- Sits directly downstream of the power management unit. Consumes its per-peripheral clock-gate-enable requests and drives the actual clock-gate enables.
- Filters each request for a minimum stable time, then negotiates a Q-channel-style quiescence handshake (QREQn/QACCEPTn/QDENY) with the peripheral.
- Asserts the gate enable only once the peripheral has accepted. On wake, the clock is re-enabled before the quiescence request is released.

Parameters:
- NUM_CH, 13, number of independent gate channels (bit i = channel i).
- HOLD_CYCLES, 4, consecutive cycles a request must be high before QREQn is asserted; legal range 0..(2^CNT_W)-1.
- CNT_W, 4, width of each per-channel hold counter.

Ports:
- CLK  in  1  system clock; single clock domain, all inputs synchronous to it.
- RESET  in  1  asynchronous, active-high reset.
- CG_DISABLE  in  1  global override; when 1, every channel's request is treated as 0.
- GATE_REQ  in  NUM_CH  per-channel gate request from the PMU (1 = stop clock).
- QACCEPTn  in  NUM_CH  peripheral accept (active low).
- QDENY  in  NUM_CH  peripheral deny (active high).
- QREQn  out  NUM_CH  quiescence request to peripheral (active low).
- GATE_EN  out  NUM_CH  clock-gate enable to the ICG (1 = clock stopped).
- DENY_SEEN  out  NUM_CH  sticky flag: channel has received a deny since reset or since the last DENY_CLR.
- DENY_CLR  in  NUM_CH  per-bit pulse that clears DENY_SEEN.

Behaviour:
- Channel structure: every channel is an identical, independent FSM with its own counter. All outputs are registered.
- Effective request: req_i = GATE_REQ[i] & ~CG_DISABLE.
- Reset values: all channels in RUN, cnt=0, QREQn=all 1s, GATE_EN=all 0s, DENY_SEEN=all 0s. Reset asserted mid-handshake returns to these values immediately (asynchronous), which ungates all clocks.
- RUN (QREQn=1, GATE_EN=0):
  - req_i=0: cnt<=0.
  - req_i=1 and cnt<HOLD_CYCLES: cnt<=cnt+1.
  - req_i=1 and cnt==HOLD_CYCLES: go to REQ, QREQn<=0.
  - Timing: QREQn falls on edge HOLD_CYCLES+1 after the first edge that samples req_i=1, i.e. edge 1 when HOLD_CYCLES=0.
  - A single low cycle of req_i restarts the count.
- REQ (QREQn=0, GATE_EN=0):
  - Waits for a response; a request cannot be withdrawn. req_i dropping here is ignored until the handshake resolves.
  - QACCEPTn=0: go to GATED, GATE_EN<=1 on the same edge.
  - QDENY=1: go to DENY, QREQn<=1, DENY_SEEN[i]<=1.
  - QACCEPTn=0 and QDENY=1 sampled together is a protocol error; accept has priority.
- GATED (QREQn=0, GATE_EN=1):
  - Holds while req_i=1.
  - req_i=0: go to EXIT, GATE_EN<=0 on that edge (clock restarts first).
- EXIT (QREQn=0, GATE_EN=0):
  - One cycle only: QREQn<=1, go to WAKE.
  - Guarantees at least one running clock edge at the peripheral before QREQn rises.
- WAKE (QREQn=1, GATE_EN=0):
  - Waits for QACCEPTn=1, then go to RUN with cnt<=0.
  - req_i is ignored while in WAKE.
- DENY (QREQn=1, GATE_EN=0):
  - Waits for QDENY=0, then go to RUN with cnt<=0.
  - A held request re-arms and retries after another HOLD_CYCLES+1 edges.
- DENY_SEEN: DENY_CLR[i] and a new deny on the same edge leaves DENY_SEEN[i]=1 (set wins).
- Invariant (assert in bench): GATE_EN[i]=1 implies QREQn[i]=0 and QACCEPTn[i]=0 was sampled on entry.
- Latency: worst case from req_i falling to GATE_EN falling is 1 edge, when in GATED. A channel in REQ must first complete the handshake.
- Counter saturation: cnt never exceeds HOLD_CYCLES, so no wrap-around.

Test Plan:
- Basic gate/ungate: HOLD_CYCLES=4, channel 2, GATE_REQ[2] 0→1 with the peripheral accepting 2 cycles after QREQn falls.
  - QREQn[2] falls at edge 5.
  - GATE_EN[2] rises at edge 7.
  - On GATE_REQ[2]→0: GATE_EN[2]=0 next edge, QREQn[2]=1 one edge later; after QACCEPTn=1 the channel returns to RUN.
- Glitch filter: GATE_REQ[0] high for 4 cycles, low 1 cycle, high again.
  - QREQn[0] stays 1 until edge 5 of the second high run.
- Deny: peripheral drives QDENY[5]=1 for 3 cycles in response to QREQn.
  - QREQn[5] returns to 1 next edge, DENY_SEEN[5]=1, GATE_EN[5] never rises.
  - Retry QREQn falls 5 edges after QDENY drops.
  - DENY_CLR[5] pulse then clears DENY_SEEN[5].
- Withdrawal in REQ plus CG_DISABLE: drop GATE_REQ while in REQ.
  - QREQn held until accept; GATED is entered for 1 cycle and the channel exits immediately.
  - CG_DISABLE=1 during RUN prevents any QREQn assertion on all 13 channels.
- Simultaneous channels and reset: all 13 channels gated.
  - Assert RESET mid-cycle: GATE_EN=0 and QREQn=all 1s asynchronously, without waiting for a clock edge.
  - HOLD_CYCLES=0 build: QREQn falls on edge 1.
